// File: rtl/pong_pkg.sv
// Shared definitions for the Pong ball sequencer.
//   - state_e      : FSM state encoding, also exposed in CTRL[2:0]
//   - ADDR_*       : Avalon-MM register addresses
//   - centre_pos() : top-left coordinate that centres the ball on an axis
//   - RESET_X/Y    : centre position for the default 640x480 screen and 8-pixel ball
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_MOVE   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_SCORED = 3'd4
  } state_e;

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_SPEED = 2'd1;
  localparam logic [1:0] ADDR_POS   = 2'd2;
  localparam logic [1:0] ADDR_SCORE = 2'd3;

  function automatic logic [15:0] centre_pos(input int unsigned extent,
                                             input int unsigned size);
    return 16'((extent - size) / 2);
  endfunction

  localparam logic [15:0] RESET_X = centre_pos(640, 8);
  localparam logic [15:0] RESET_Y = centre_pos(480, 8);

endpackage

// File: rtl/pong_paddle_hit.sv
// Combinational vertical-overlap test between the ball and one paddle.
//   ball_y   : ball top edge y
//   paddle_y : paddle top edge y
//   hit      : 1 when ball_y+BALL_SIZE > paddle_y and ball_y < paddle_y+PADDLE_H
module pong_paddle_hit #(
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned PADDLE_H  = 64
) (
  input  logic [15:0] ball_y,
  input  logic [15:0] paddle_y,
  output logic        hit
);

  // One extra bit so the bottom-edge sums cannot wrap.
  logic [16:0] ball_bot;
  logic [16:0] pad_bot;

  assign ball_bot = {1'b0, ball_y} + 17'(BALL_SIZE);
  assign pad_bot  = {1'b0, paddle_y} + 17'(PADDLE_H);
  assign hit      = (ball_bot > {1'b0, paddle_y}) && ({1'b0, ball_y} < pad_bot);

endmodule

// File: rtl/pong_ball_ctrl.sv
// Pong ball sequencer with an Avalon-MM slave register file.
// Once per frame_tick (accepted in WAIT) the ball is moved (MOVE), wall/paddle
// bounces and goals are resolved (CHECK), and a goal updates the score (SCORED).
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   address/chipselect/
//   write_n/writedata       : register writes (write = chipselect & ~write_n)
//   readdata                : combinational read mux on address
//   frame_tick              : one-cycle frame pulse
//   paddle_l_y, paddle_r_y  : paddle top edges
//   ball_x, ball_y          : ball top-left position to the renderer
//   irq                     : score interrupt
// Build option: PONG_BALL_IRQ_EN enables irq (set on score, cleared by a SCORE
// write) and CTRL read bit 3; without it irq is tied low.
module pong_ball_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned PADDLE_H  = 64,
  parameter int unsigned PADDLE_W  = 8,
  parameter int unsigned PADDLE_XL = 16,
  parameter int unsigned PADDLE_XR = 616
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        frame_tick,
  input  logic [15:0] paddle_l_y,
  input  logic [15:0] paddle_r_y,
  output logic [15:0] ball_x,
  output logic [15:0] ball_y,
  output logic        irq
);

  localparam logic [15:0]        CX      = centre_pos(SCREEN_W, BALL_SIZE);
  localparam logic [15:0]        CY      = centre_pos(SCREEN_H, BALL_SIZE);
  localparam logic signed [16:0] Y_MAX   = 17'(SCREEN_H - BALL_SIZE);
  localparam logic signed [16:0] X_MAX   = 17'(SCREEN_W - BALL_SIZE);
  localparam logic signed [16:0] X_LCLMP = 17'(PADDLE_XL + PADDLE_W);
  localparam logic signed [16:0] X_RCLMP = 17'(PADDLE_XR - BALL_SIZE);

  state_e             state_q, state_d;
  logic [15:0]        x_q, x_d, y_q, y_d;
  logic               dir_x_q, dir_x_d, dir_y_q, dir_y_d;   // 1 = increasing
  logic [7:0]         dx_q, dx_d, dy_q, dy_d;
  logic               run_q, run_d;
  logic [7:0]         score_l_q, score_l_d, score_r_q, score_r_d;
  logic signed [16:0] nx_q, nx_d, ny_q, ny_d;

  logic        wr, wr_ctrl;
  logic [15:0] y_res;
  logic        dir_y_res;
  logic        hit_l, hit_r;
  logic        irq_rd;
  logic        unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wr_ctrl      = wr && (address == ADDR_CTRL);
  assign unused_wdata = ^writedata[31:16];

  // Y-wall resolution is kept apart from the main next-state block so the
  // paddle overlap tests can use the clamped y without a combinational loop.
  always_comb begin
    y_res     = ny_q[15:0];
    dir_y_res = dir_y_q;
    if (ny_q < 0) begin
      y_res     = '0;
      dir_y_res = 1'b1;
    end else if (ny_q > Y_MAX) begin
      y_res     = Y_MAX[15:0];
      dir_y_res = 1'b0;
    end
  end

  pong_paddle_hit #(.BALL_SIZE(BALL_SIZE), .PADDLE_H(PADDLE_H)) u_hit_l (
    .ball_y   (y_res),
    .paddle_y (paddle_l_y),
    .hit      (hit_l)
  );

  pong_paddle_hit #(.BALL_SIZE(BALL_SIZE), .PADDLE_H(PADDLE_H)) u_hit_r (
    .ball_y   (y_res),
    .paddle_y (paddle_r_y),
    .hit      (hit_r)
  );

`ifdef PONG_BALL_IRQ_EN
  logic irq_q, irq_d;
  assign irq    = irq_q;
  assign irq_rd = irq_q;
`else
  assign irq    = 1'b0;
  assign irq_rd = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    run_d     = run_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    nx_d      = nx_q;
    ny_d      = ny_q;
`ifdef PONG_BALL_IRQ_EN
    irq_d     = irq_q;
    if (wr && (address == ADDR_SCORE)) irq_d = 1'b0;
`endif

    if (wr_ctrl) run_d = writedata[0];
    if (wr && (address == ADDR_SPEED)) begin
      dx_d = (writedata[7:0]  == 8'd0) ? 8'd1 : writedata[7:0];
      dy_d = (writedata[15:8] == 8'd0) ? 8'd1 : writedata[15:8];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (wr_ctrl && writedata[1] && run_d) begin
          x_d     = CX;
          y_d     = CY;
          dir_x_d = ~dir_x_q;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!run_q)          state_d = ST_IDLE;
        else if (frame_tick) state_d = ST_MOVE;
      end
      ST_MOVE: begin
        nx_d = dir_x_q ? ($signed({1'b0, x_q}) + $signed({9'b0, dx_q}))
                       : ($signed({1'b0, x_q}) - $signed({9'b0, dx_q}));
        ny_d = dir_y_q ? ($signed({1'b0, y_q}) + $signed({9'b0, dy_q}))
                       : ($signed({1'b0, y_q}) - $signed({9'b0, dy_q}));
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        y_d     = y_res;
        dir_y_d = dir_y_res;
        x_d     = nx_q[15:0];
        state_d = run_q ? ST_WAIT : ST_IDLE;
        // On a goal x is held on-screen; SCORED recentres the ball anyway.
        // dir_x is left unchanged so SCORED knows which side conceded.
        if (!dir_x_q) begin
          if ((nx_q <= X_LCLMP) && hit_l) begin
            x_d     = X_LCLMP[15:0];
            dir_x_d = 1'b1;
          end else if (nx_q < 0) begin
            x_d     = x_q;
            state_d = ST_SCORED;
          end
        end else begin
          if ((nx_q >= X_RCLMP) && hit_r) begin
            x_d     = X_RCLMP[15:0];
            dir_x_d = 1'b0;
          end else if (nx_q > X_MAX) begin
            x_d     = x_q;
            state_d = ST_SCORED;
          end
        end
      end
      ST_SCORED: begin
        if (!dir_x_q) begin
          if (score_r_q != 8'hFF) score_r_d = score_r_q + 8'd1;
        end else begin
          if (score_l_q != 8'hFF) score_l_d = score_l_q + 8'd1;
        end
        x_d     = CX;
        y_d     = CY;
        state_d = ST_IDLE;
`ifdef PONG_BALL_IRQ_EN
        irq_d   = 1'b1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied last so it overrides a same-cycle score increment.
    if (wr_ctrl && writedata[2]) begin
      score_l_d = '0;
      score_r_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      x_q       <= CX;
      y_q       <= CY;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      dx_q      <= 8'd2;
      dy_q      <= 8'd2;
      run_q     <= 1'b0;
      score_l_q <= '0;
      score_r_q <= '0;
      nx_q      <= '0;
      ny_q      <= '0;
`ifdef PONG_BALL_IRQ_EN
      irq_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      run_q     <= run_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      nx_q      <= nx_d;
      ny_q      <= ny_d;
`ifdef PONG_BALL_IRQ_EN
      irq_q     <= irq_d;
`endif
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_CTRL:  readdata = {28'b0, irq_rd, 3'(state_q)};
      ADDR_SPEED: readdata = {16'b0, dy_q, dx_q};
      ADDR_POS:   readdata = {y_q, x_q};
      ADDR_SCORE: readdata = {16'b0, score_r_q, score_l_q};
      default:    readdata = '0;
    endcase
  end

  assign ball_x = x_q;
  assign ball_y = y_q;

endmodule
